// File: rtl/pic_host_ctrl.sv
// -----------------------------------------------------------------------------
// pic_host_ctrl
//
// CPU-side bus master for an 8259-style interrupt controller. Converts simple
// command requests into CS/A0/RD/WR bus cycles (ICW/OCW writes, IRR/ISR/IMR
// reads). When INT is raised it runs the two-pulse INTA acknowledge and
// captures the vector driven during the second pulse.
//
// Optional build macro:
//   PIC_HOST_INT_SYNC_EN - int_in passes through a 2-flop synchronizer before
//                          arbitration (adds 2 clocks of acknowledge latency).
//                          Undefined: int_in is sampled directly.
//
// Parameters:
//   STROBE_CYCLES - low time of rd_n/wr_n/inta_n in clocks (>= 1)
//   GAP_CYCLES    - inta_n high time between the two INTA pulses (>= 1)
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   cmd_valid/ready  command handshake (ready only in an arbitrating IDLE)
//   cmd_write        1 = bus write, 0 = bus read
//   cmd_a0, cmd_data address bit and write data of the command
//   rsp_valid/data   one-cycle read response
//   vector_valid/vector  one-cycle interrupt vector report
//   busy             FSM not in IDLE
//   int_in           INT from the controller
//   cs_n, rd_n, wr_n, inta_n, a0, dout   bus outputs (all registered)
//   din              read/vector data bus from the controller
// -----------------------------------------------------------------------------
module pic_host_ctrl #(
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       vector_valid,
  output logic [7:0] vector,
  output logic       busy,
  input  logic       int_in,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       inta_n,
  output logic       a0,
  output logic [7:0] dout,
  input  logic [7:0] din
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_INTA1  = 3'd4;
  localparam logic [2:0] ST_GAP    = 3'd5;
  localparam logic [2:0] ST_INTA2  = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

  // Terminal counts: counters run 0 .. N-1 inside a multi-cycle state.
  localparam logic [15:0] STROBE_LAST = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);

  logic [2:0]  state_r;
  logic [15:0] cnt_r;
  logic        arb_ok_r;  // IDLE has served its mandatory quiet cycle
  logic        write_r;   // latched direction of the command in flight
  logic        int_s;     // interrupt request as seen by the arbiter

`ifdef PIC_HOST_INT_SYNC_EN
  logic [1:0] int_sync_r;

  // Two-flop synchronizer for an INT driven from another clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_sync_r <= 2'b00;
    end else begin
      int_sync_r <= {int_sync_r[0], int_in};
    end
  end

  assign int_s = int_sync_r[1];
`else
  assign int_s = int_in;
`endif

  // Bus sequencer: state, cycle counter and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 16'd0;
      arb_ok_r     <= 1'b0;
      write_r      <= 1'b0;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 8'h00;
      vector_valid <= 1'b0;
      vector       <= 8'h00;
      busy         <= 1'b0;
      cs_n         <= 1'b1;
      rd_n         <= 1'b1;
      wr_n         <= 1'b1;
      inta_n       <= 1'b1;
      a0           <= 1'b0;
      dout         <= 8'h00;
    end else begin
      // Report pulses last exactly one cycle.
      rsp_valid    <= 1'b0;
      vector_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!arb_ok_r) begin
            // Quiet cycle after returning to IDLE (or leaving reset).
            arb_ok_r  <= 1'b1;
            cmd_ready <= !int_s;
          end else if (int_s) begin
            // Acknowledge wins over a simultaneous command.
            state_r   <= ST_INTA1;
            cnt_r     <= 16'd0;
            arb_ok_r  <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            cs_n      <= 1'b1;
            inta_n    <= 1'b0;
          end else if (cmd_valid && cmd_ready) begin
            state_r   <= ST_SETUP;
            arb_ok_r  <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            write_r   <= cmd_write;
            a0        <= cmd_a0;
            cs_n      <= 1'b0;
            // Reads leave the write bus at its previous value.
            if (cmd_write) begin
              dout <= cmd_data;
            end else begin
              dout <= dout;
            end
          end else begin
            cmd_ready <= !int_s;
          end
        end

        ST_SETUP: begin
          state_r <= ST_STROBE;
          cnt_r   <= 16'd0;
          if (write_r) begin
            wr_n <= 1'b0;
          end else begin
            rd_n <= 1'b0;
          end
        end

        ST_STROBE: begin
          if (cnt_r == STROBE_LAST) begin
            state_r <= ST_HOLD;
            wr_n    <= 1'b1;
            rd_n    <= 1'b1;
            // Read data is taken on the edge that ends the strobe.
            if (!write_r) begin
              rsp_data  <= din;
              rsp_valid <= 1'b1;
            end else begin
              rsp_data  <= rsp_data;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end

        ST_HOLD: begin
          state_r <= ST_IDLE;
          cs_n    <= 1'b1;
          busy    <= 1'b0;
        end

        ST_INTA1: begin
          if (cnt_r == STROBE_LAST) begin
            state_r <= ST_GAP;
            cnt_r   <= 16'd0;
            inta_n  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end

        ST_GAP: begin
          if (cnt_r == GAP_LAST) begin
            state_r <= ST_INTA2;
            cnt_r   <= 16'd0;
            inta_n  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end

        ST_INTA2: begin
          // A dropped INT does not abort; the vector is captured regardless.
          if (cnt_r == STROBE_LAST) begin
            state_r      <= ST_DONE;
            inta_n       <= 1'b1;
            vector       <= din;
            vector_valid <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end

        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end

        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= 16'd0;
          arb_ok_r  <= 1'b0;
          cmd_ready <= 1'b0;
          busy      <= 1'b0;
          cs_n      <= 1'b1;
          rd_n      <= 1'b1;
          wr_n      <= 1'b1;
          inta_n    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pic_host_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pic_host_ctrl
//
// Self-checking bench for pic_host_ctrl (default build, STROBE_CYCLES=2,
// GAP_CYCLES=2). Each bus operation is expanded into a per-cycle timeline of
// {inputs, expected outputs} records from the bus-cycle rules (cycle k after
// acceptance), then applied and compared in one loop. A behavioural PIC drives
// din from the strobes. Reset cases are written out by hand.
// -----------------------------------------------------------------------------
module tb_pic_host_ctrl;

  localparam int S = 2;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic       cmd_a0 = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       int_in = 1'b0;
  logic       cmd_ready, rsp_valid, vector_valid, busy;
  logic       cs_n, rd_n, wr_n, inta_n, a0;
  logic [7:0] rsp_data, vector, dout, din;

  always #5 clk = ~clk;

  pic_host_ctrl #(.STROBE_CYCLES(S), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_a0(cmd_a0), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .vector_valid(vector_valid), .vector(vector), .busy(busy),
    .int_in(int_in), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .inta_n(inta_n),
    .a0(a0), .dout(dout), .din(din)
  );

  // Behavioural PIC: read data while rd_n is low, vector during every second
  // INTA pulse, a distinct filler value otherwise.
  logic [7:0] pic_rd_val = 8'h00;
  logic [7:0] pic_vec_val = 8'h00;
  int         inta_ends = 0;

  always @(posedge inta_n) begin
    if (!rst) inta_ends = inta_ends + 1;
  end

  assign din = (!rd_n) ? pic_rd_val :
               ((!inta_n && (inta_ends % 2) == 1) ? pic_vec_val : 8'hEE);

  typedef struct {
    logic       cv, cw, ca0, ii;
    logic [7:0] cd, rv, vv;
    logic       e_cs_n, e_rd_n, e_wr_n, e_inta_n, e_busy, e_ready;
    logic       e_rsp_valid, e_vec_valid, e_a0;
    logic [7:0] e_rsp_data, e_vector, e_dout;
  } cyc_t;

  typedef struct {
    int         kind;   // 0 write, 1 read, 2 INTA, 3 INTA with command waiting
    logic       a0;
    logic [7:0] data;   // write data, or command data for kind 3
    logic [7:0] pic;    // din for reads, vector for INTA
  } op_t;

  cyc_t       trace[$];
  logic [7:0] m_dout = 8'h00, m_rsp = 8'h00, m_vec = 8'h00;
  logic       m_a0 = 1'b0;
  int         checks = 0;
  int         failures = 0;
  int         cyc_no = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: actual=%b required=%b", name, cyc_no, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: actual=%h required=%h", name, cyc_no, act, exp);
    end
  endtask

  // Idle-bus expectation with the currently held data values.
  function automatic cyc_t blank(input logic ready, input logic bsy);
    cyc_t c;
    c.cv = 1'b0; c.cw = 1'b0; c.ca0 = 1'b0; c.ii = 1'b0;
    c.cd = 8'h00; c.rv = 8'h00; c.vv = 8'h00;
    c.e_cs_n = 1'b1; c.e_rd_n = 1'b1; c.e_wr_n = 1'b1; c.e_inta_n = 1'b1;
    c.e_busy = bsy; c.e_ready = ready;
    c.e_rsp_valid = 1'b0; c.e_vec_valid = 1'b0;
    c.e_a0 = m_a0; c.e_rsp_data = m_rsp; c.e_vector = m_vec; c.e_dout = m_dout;
    return c;
  endfunction

  // Command: k=0 handshake, k=1 setup, k=2..S+1 strobe, k=S+2 hold, k=S+3 quiet.
  task automatic add_cmd(input logic w, input logic a, input logic [7:0] d,
                         input logic [7:0] rv, input bit noise);
    cyc_t c;
    c = blank(1'b1, 1'b0);
    c.cv = 1'b1; c.cw = w; c.ca0 = a; c.cd = d; c.rv = rv;
    trace.push_back(c);
    m_a0 = a;
    if (w) m_dout = d;
    for (int k = 1; k <= S + 3; k++) begin
      if (k == S + 2 && !w) m_rsp = rv;
      c = blank(1'b0, (k <= S + 2) ? 1'b1 : 1'b0);
      c.rv = rv;
      if (k <= S + 2) c.e_cs_n = 1'b0;
      if (k >= 2 && k <= S + 1) begin
        if (w) c.e_wr_n = 1'b0;
        else   c.e_rd_n = 1'b0;
      end
      c.e_rsp_valid = (!w && k == S + 2) ? 1'b1 : 1'b0;
      if (noise) begin
        c.cv  = 1'($urandom_range(1, 0));
        c.cw  = 1'($urandom_range(1, 0));
        c.ca0 = 1'($urandom_range(1, 0));
        c.cd  = 8'($urandom);
        if (k <= S + 2) c.ii = 1'($urandom_range(1, 0));
      end
      trace.push_back(c);
    end
  endtask

  // Acknowledge: INTA1 k=1..S, GAP, INTA2, DONE at 2S+G+1, quiet cycle after.
  // INT stays high through the first pulse only (unless noise toggles it later).
  task automatic add_inta(input logic [7:0] vec, input bit hold, input logic w,
                          input logic a, input logic [7:0] d, input bit noise);
    cyc_t c;
    for (int k = 0; k <= 2 * S + G + 2; k++) begin
      if (k == 2 * S + G + 1) m_vec = vec;
      c = blank((k == 0) ? 1'b1 : 1'b0, (k >= 1 && k <= 2 * S + G + 1) ? 1'b1 : 1'b0);
      c.vv = vec;
      if (hold) begin
        c.cv = 1'b1; c.cw = w; c.ca0 = a; c.cd = d;
      end else if (noise) begin
        c.cv  = 1'($urandom_range(1, 0));
        c.cw  = 1'($urandom_range(1, 0));
        c.ca0 = 1'($urandom_range(1, 0));
        c.cd  = 8'($urandom);
      end
      if (k <= S) c.ii = 1'b1;
      else if (noise && k <= 2 * S + G) c.ii = 1'($urandom_range(1, 0));
      if ((k >= 1 && k <= S) || (k >= S + G + 1 && k <= 2 * S + G)) c.e_inta_n = 1'b0;
      c.e_vec_valid = (k == 2 * S + G + 1) ? 1'b1 : 1'b0;
      trace.push_back(c);
    end
  endtask

  task automatic add_op(input op_t op, input bit noise);
    case (op.kind)
      0: add_cmd(1'b1, op.a0, op.data, 8'h00, noise);
      1: add_cmd(1'b0, op.a0, 8'h00, op.pic, noise);
      2: add_inta(op.pic, 1'b0, 1'b0, 1'b0, 8'h00, noise);
      default: begin
        add_inta(op.pic, 1'b1, 1'b1, op.a0, op.data, noise);
        add_cmd(1'b1, op.a0, op.data, 8'h00, noise);
      end
    endcase
  endtask

  // Starts at the negedge of an arbitrating IDLE cycle; compare, then drive.
  task automatic run_trace();
    for (int i = 0; i < trace.size(); i++) begin
      cyc_t c;
      c = trace[i];
      chk1("cs_n", cs_n, c.e_cs_n);
      chk1("rd_n", rd_n, c.e_rd_n);
      chk1("wr_n", wr_n, c.e_wr_n);
      chk1("inta_n", inta_n, c.e_inta_n);
      chk1("busy", busy, c.e_busy);
      chk1("cmd_ready", cmd_ready, c.e_ready);
      chk1("rsp_valid", rsp_valid, c.e_rsp_valid);
      chk1("vector_valid", vector_valid, c.e_vec_valid);
      chk1("a0", a0, c.e_a0);
      chk8("dout", dout, c.e_dout);
      chk8("rsp_data", rsp_data, c.e_rsp_data);
      chk8("vector", vector, c.e_vector);
      cmd_valid   = c.cv;
      cmd_write   = c.cw;
      cmd_a0      = c.ca0;
      cmd_data    = c.cd;
      int_in      = c.ii;
      pic_rd_val  = c.rv;
      pic_vec_val = c.vv;
      cyc_no++;
      @(negedge clk);
    end
    trace.delete();
  endtask

  // Keeps the run bounded no matter what the design does.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t table_ops[7];
    op_t rop;

    table_ops[0] = '{kind: 0, a0: 1'b0, data: 8'h1B, pic: 8'h00};
    table_ops[1] = '{kind: 0, a0: 1'b1, data: 8'h55, pic: 8'h00};
    table_ops[2] = '{kind: 1, a0: 1'b0, data: 8'h00, pic: 8'h96};
    table_ops[3] = '{kind: 2, a0: 1'b0, data: 8'h00, pic: 8'h51};
    table_ops[4] = '{kind: 3, a0: 1'b1, data: 8'hA5, pic: 8'h2C};
    table_ops[5] = '{kind: 1, a0: 1'b1, data: 8'h00, pic: 8'h3C};
    table_ops[6] = '{kind: 0, a0: 1'b0, data: 8'hFF, pic: 8'h00};

    // Reset state while rst is held.
    repeat (3) @(negedge clk);
    chk1("rst_cs_n", cs_n, 1'b1);
    chk1("rst_rd_n", rd_n, 1'b1);
    chk1("rst_wr_n", wr_n, 1'b1);
    chk1("rst_inta_n", inta_n, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_vector_valid", vector_valid, 1'b0);
    chk1("rst_a0", a0, 1'b0);
    chk8("rst_dout", dout, 8'h00);
    chk8("rst_rsp_data", rsp_data, 8'h00);
    chk8("rst_vector", vector, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Directed table, then a trailing idle check.
    for (int i = 0; i < 7; i++) add_op(table_ops[i], 1'b0);
    trace.push_back(blank(1'b1, 1'b0));
    run_trace();

    // Reset in the middle of a write strobe.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_a0 = 1'b1; cmd_data = 8'h77;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk1("mid_wr_n_low", wr_n, 1'b0);
    chk1("mid_cs_n_low", cs_n, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk1("async_wr_n", wr_n, 1'b1);
    chk1("async_cs_n", cs_n, 1'b1);
    chk1("async_busy", busy, 1'b0);
    chk1("async_cmd_ready", cmd_ready, 1'b0);
    chk8("async_dout", dout, 8'h00);
    chk1("async_a0", a0, 1'b0);
    @(negedge clk);
    chk1("rst_hold_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_hold_vector_valid", vector_valid, 1'b0);
    chk1("rst_hold_wr_n", wr_n, 1'b1);
    rst = 1'b0;
    m_dout = 8'h00; m_rsp = 8'h00; m_vec = 8'h00; m_a0 = 1'b0;
    @(negedge clk);
    add_cmd(1'b0, 1'b0, 8'h00, 8'hC3, 1'b0);
    run_trace();

    // Randomized operation stream with ignored-input noise.
    for (int i = 0; i < 40; i++) begin
      rop.kind = int'($urandom_range(3, 0));
      rop.a0   = 1'($urandom_range(1, 0));
      rop.data = 8'($urandom);
      rop.pic  = 8'($urandom);
      add_op(rop, 1'b1);
    end
    trace.push_back(blank(1'b1, 1'b0));
    run_trace();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pic_host_ctrl.md
# pic_host_ctrl

CPU-side bus master for the 8259-style interrupt controller. It turns simple command requests into RD/WR/CS/A0 bus cycles for programming (ICW/OCW writes) and for status reads (IRR/ISR/IMR). When the controller raises INT, it runs the two-pulse INTA acknowledge sequence and captures the vector the controller drives during the second pulse. It sits between a host/processor model and the interrupt controller's bus pins.

## Interface
Parameters:
- STROBE_CYCLES, 2: low time of rd_n/wr_n/inta_n in clocks (legal ≥1).
- GAP_CYCLES, 2: high time of inta_n between the two INTA pulses (legal ≥1).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE with no acknowledge pending.
- cmd_write  in  1  1 = bus write, 0 = bus read.
- cmd_a0  in  1  value driven on a0 for the command.
- cmd_data  in  8  write data.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid.
- rsp_data  out  8  read data captured from din.
- vector_valid  out  1  one-cycle pulse; vector is valid.
- vector  out  8  vector captured during the second INTA pulse.
- busy  out  1  FSM is not in IDLE.
- int_in  in  1  INT from the interrupt controller, active-high.
- cs_n, rd_n, wr_n, inta_n  out  1 each  bus strobes, active-low.
- a0  out  1  address bit.
- dout  out  8  write data bus to the controller.
- din  in  8  read/vector data bus from the controller.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, INTA1, GAP, INTA2, DONE.
- Arbitration in IDLE: if int_in (after the optional synchronizer) is high, go to INTA1. Otherwise, if cmd_valid && cmd_ready, latch cmd_write/cmd_a0/cmd_data and go to SETUP. The acknowledge path wins over a simultaneous command. cmd_ready is low in any cycle where int_in is high in IDLE.
- SETUP (1 cycle): cs_n=0, a0=latched, dout=latched data (writes only), strobes high.
- STROBE (STROBE_CYCLES): wr_n=0 or rd_n=0; cs_n, a0 and dout held. For reads, rsp_data samples din on the last STROBE cycle.
- HOLD (1 cycle): strobe high, cs_n=0, a0/dout held. rsp_valid=1 for reads. Next state is IDLE.
- INTA1 (STROBE_CYCLES): inta_n=0, cs_n=1.
- GAP (GAP_CYCLES): inta_n=1.
- INTA2 (STROBE_CYCLES): inta_n=0. vector samples din on the last cycle.
- DONE (1 cycle): vector_valid=1. Next state is IDLE.
- After every return to IDLE, one IDLE cycle elapses before the next arbitration. A still-high int_in then starts a new acknowledge.
- int_in falling during INTA1/GAP/INTA2 does not abort the sequence; the vector is captured anyway.
- cmd_valid changes while busy are ignored; nothing is queued.
- Unused outputs hold their last value: dout, a0, rsp_data, vector.

## Timing
- Reset values: cs_n=rd_n=wr_n=inta_n=1, a0=0, dout=0, rsp_valid=0, rsp_data=0, vector_valid=0, vector=0, busy=0, cmd_ready=0 during reset and 1 in the first IDLE cycle after reset (int_in low). FSM=IDLE.
- Reset asserted mid-cycle forces all outputs to reset values immediately (asynchronous). No partial strobe completes.
- Handshake accepted at edge T → cs_n low from T+1. The write occupies 2+STROBE_CYCLES clocks, then cmd_ready is high again after the mandatory idle cycle.
- Read latency, accept → rsp_valid: 2+STROBE_CYCLES clocks.
- INT seen in IDLE at edge T → inta_n low from T+1. vector_valid occurs 2·STROBE_CYCLES+GAP_CYCLES+1 clocks after T.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- PIC_HOST_INT_SYNC_EN defined: int_in passes through a 2-flop synchronizer (reset 0) before arbitration. Acknowledge start latency grows by 2 clocks.
- Undefined: int_in is sampled directly (same clock domain assumed).

## Test plan
- Reset release, idle bus → all strobes 1, busy=0, cmd_ready=1, no pulses.
- Write cmd a0=0 data 0x1B, STROBE_CYCLES=2 → cs_n low 4 clocks, wr_n low exactly clocks 2–3, dout=0x1B, a0=0 throughout. Then ICW2 0x55 with a0=1 → same shape, dout=0x55.
- Read cmd a0=0, behavioural PIC drives din=0x96 → rsp_valid single pulse 4 clocks after accept, rsp_data=0x96, wr_n never low.
- int_in high, PIC drives din=0x51 during the second pulse → two inta_n pulses of 2 clocks separated by 2 high clocks, cs_n=1, vector_valid pulse with vector=0x51. The PIC drops INT after the first pulse, so there is no second sequence.
- int_in and cmd_valid rise in the same IDLE cycle → INTA sequence runs first, then the command executes after the idle cycle.
- rst asserted during STROBE of a write → wr_n/cs_n return to 1 asynchronously, FSM=IDLE, no rsp_valid/vector_valid.
